// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall / flush sequencing for the 5-stage MIPS pipeline
// Optional stall counter enabled by `define PIPE_STALL_CNT_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int FILL_CYCLES = 4,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  IDRs,
  input  logic [4:0]  IDRt,
  input  logic        IDUsesRt,
  input  logic        EXMemRead,
  input  logic [4:0]  EXRegDest,
  input  logic        BranchTaken,
  input  logic        MemReq,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        EXMEMWrite,
  output logic        MEMWBWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic        MEMWBFlush,
  output logic        MemTimeoutErr
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_MEMWAIT = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  localparam logic [3:0] c_fillLoad = 4'(FILL_CYCLES - 1);
  localparam logic [7:0] c_toLast   = 8'(MEM_TIMEOUT - 1);

  // Control vector: {PC, IFID, IDEX, EXMEM, MEMWB writes, IFID, IDEX, EXMEM, MEMWB flushes}
  localparam logic [8:0] c_ctlOff      = 9'b0_0000_0000;
  localparam logic [8:0] c_ctlFill     = 9'b0_1111_1111;
  localparam logic [8:0] c_ctlNormal   = 9'b1_1111_0000;
  localparam logic [8:0] c_ctlMemStall = 9'b0_0001_0001;
  localparam logic [8:0] c_ctlBranch   = 9'b1_1111_1100;
  localparam logic [8:0] c_ctlLoadUse  = 9'b0_0111_0100;

  logic [1:0] r_state;
  logic [1:0] w_nextState;
  logic [3:0] r_fillCnt;
  logic [3:0] w_fillNext;
  logic [7:0] r_toCnt;
  logic [7:0] w_toNext;
  logic       r_memTimeoutErr;

  logic       w_memStall;
  logic       w_loadUse;
  logic [8:0] w_runCtl;
  logic [8:0] w_ctl;
  logic [8:0] w_ctlOut;

  assign w_memStall = MemReq & ~MemReady;
  assign w_loadUse  = EXMemRead & (EXRegDest != 5'd0) &
                      ((EXRegDest == IDRs) | (IDUsesRt & (EXRegDest == IDRt)));

  // A taken branch squashes the ID instruction, so it outranks load-use.
  always_comb begin
    w_runCtl = c_ctlNormal;
    if (w_memStall) begin
      w_runCtl = c_ctlMemStall;
    end else if (BranchTaken) begin
      w_runCtl = c_ctlBranch;
    end else if (w_loadUse) begin
      w_runCtl = c_ctlLoadUse;
    end
  end

  always_comb begin
    w_ctl       = c_ctlOff;
    w_nextState = r_state;
    w_fillNext  = r_fillCnt;
    w_toNext    = r_toCnt;
    case (r_state)
      ST_INIT: begin
        w_ctl = c_ctlFill;
        if (r_fillCnt == 4'd0) begin
          w_nextState = ST_RUN;
        end else begin
          w_fillNext = r_fillCnt - 4'd1;
        end
      end
      ST_RUN: begin
        w_ctl = w_runCtl;
        if (w_memStall) begin
          w_nextState = ST_MEMWAIT;
          w_toNext    = 8'd1;
        end
      end
      ST_MEMWAIT: begin
        if (MemReady) begin
          w_ctl       = w_runCtl;
          w_nextState = ST_RUN;
        end else begin
          w_ctl = c_ctlMemStall;
          if (r_toCnt == c_toLast) begin
            w_nextState = ST_ERROR;
          end else if (r_toCnt != 8'hFF) begin
            w_toNext = r_toCnt + 8'd1;
          end
        end
      end
      ST_ERROR: begin
        w_ctl = c_ctlOff;
      end
      default: begin
        w_ctl       = c_ctlOff;
        w_nextState = ST_INIT;
      end
    endcase
  end

  // Outputs drop to zero the moment reset asserts, independent of the clock.
  assign w_ctlOut = Rst_n ? w_ctl : c_ctlOff;

  assign PCWrite    = w_ctlOut[8];
  assign IFIDWrite  = w_ctlOut[7];
  assign IDEXWrite  = w_ctlOut[6];
  assign EXMEMWrite = w_ctlOut[5];
  assign MEMWBWrite = w_ctlOut[4];
  assign IFIDFlush  = w_ctlOut[3];
  assign IDEXFlush  = w_ctlOut[2];
  assign EXMEMFlush = w_ctlOut[1];
  assign MEMWBFlush = w_ctlOut[0];
  assign MemTimeoutErr = r_memTimeoutErr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state         <= ST_INIT;
      r_fillCnt       <= c_fillLoad;
      r_toCnt         <= 8'd0;
      r_memTimeoutErr <= 1'b0;
    end else begin
      r_state         <= w_nextState;
      r_fillCnt       <= w_fillNext;
      r_toCnt         <= w_toNext;
      r_memTimeoutErr <= r_memTimeoutErr | (w_nextState == ST_ERROR);
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] r_stallCnt;
  logic        w_stallInc;

  assign w_stallInc = ((r_state == ST_RUN) || (r_state == ST_MEMWAIT)) &&
                      !w_ctl[8] && (r_stallCnt != 16'hFFFF);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_stallCnt <= 16'd0;
    end else if (w_stallInc) begin
      r_stallCnt <= r_stallCnt + 16'd1;
    end
  end

  assign StallCount = r_stallCnt;
`endif

endmodule

`default_nettype wire
